// File: rtl/byte_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : byte_bus_arbiter
//  Purpose  : Round-robin, burst-limited arbiter sharing one registered byte
//             bus between requester A and requester B. A 2:1 byte mux
//             (select = sel) feeds a register that drives out_data/out_valid.
//  Ports    : clk, rst (synchronous, active-high)
//             req_a/data_a, req_b/data_b : requester inputs
//             out_ready                  : downstream accepts a byte
//             gnt_a/gnt_b                : registered ownership decode
//             ack_a/ack_b                : combinational byte-taken strobes
//             sel                        : mux select, 0 = A, 1 = B
//             out_data/out_valid         : registered bus byte / new-byte flag
//  Option   : BYTE_ARB_STATS_EN adds xfer_cnt_a, xfer_cnt_b (16 bit) and
//             switch_cnt (8 bit) statistic counters.
//  Revision : 1.0 - initial release
// ============================================================================
module byte_bus_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic             out_ready,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             ack_a,
    output logic             ack_b,
    output logic             sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
`ifdef BYTE_ARB_STATS_EN
    ,
    output logic [15:0]      xfer_cnt_a,
    output logic [15:0]      xfer_cnt_b,
    output logic [7:0]       switch_cnt
`endif
);

    // Index of the final transfer of a burst.
    localparam logic [3:0] c_LAST_CNT = 4'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last;          // 0 = A owned last, 1 = B owned last
    logic [3:0]        r_burst_cnt;
    logic [3:0]        w_burst_cnt_nxt;
    logic              r_sel;
    logic [WIDTH-1:0]  r_out_data;
    logic              r_out_valid;
    logic              w_xfer_a;
    logic              w_xfer_b;

    assign gnt_a     = (r_state == ST_GNT_A);
    assign gnt_b     = (r_state == ST_GNT_B);
    assign w_xfer_a  = gnt_a & req_a & out_ready;
    assign w_xfer_b  = gnt_b & req_b & out_ready;
    assign ack_a     = w_xfer_a;
    assign ack_b     = w_xfer_b;
    assign sel       = r_sel;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

    // Next-state and burst counter.
    always_comb begin
        w_state_nxt     = r_state;
        w_burst_cnt_nxt = r_burst_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req_a && req_b)
                    w_state_nxt = r_last ? ST_GNT_A : ST_GNT_B;
                else if (req_a)
                    w_state_nxt = ST_GNT_A;
                else if (req_b)
                    w_state_nxt = ST_GNT_B;
            end
            ST_GNT_A: begin
                if (!req_a) begin
                    w_state_nxt = req_b ? ST_GNT_B : ST_IDLE;
                end else if (out_ready) begin
                    if (r_burst_cnt == c_LAST_CNT) begin
                        // Burst exhausted: yield only if B is actually waiting.
                        if (req_b)
                            w_state_nxt = ST_GNT_B;
                        else
                            w_burst_cnt_nxt = 4'd0;
                    end else begin
                        w_burst_cnt_nxt = r_burst_cnt + 4'd1;
                    end
                end
            end
            ST_GNT_B: begin
                if (!req_b) begin
                    w_state_nxt = req_a ? ST_GNT_A : ST_IDLE;
                end else if (out_ready) begin
                    if (r_burst_cnt == c_LAST_CNT) begin
                        if (req_a)
                            w_state_nxt = ST_GNT_A;
                        else
                            w_burst_cnt_nxt = 4'd0;
                    end else begin
                        w_burst_cnt_nxt = r_burst_cnt + 4'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // A fresh grant always starts a fresh burst.
        if ((w_state_nxt != r_state) && (w_state_nxt != ST_IDLE))
            w_burst_cnt_nxt = 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b1;            // B "owned last" so A wins first tie
            r_burst_cnt <= 4'd0;
            r_sel       <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
            // sel and last both track the owner; in IDLE they keep history.
            if (w_state_nxt == ST_GNT_A) begin
                r_sel  <= 1'b0;
                r_last <= 1'b0;
            end else if (w_state_nxt == ST_GNT_B) begin
                r_sel  <= 1'b1;
                r_last <= 1'b1;
            end
            r_out_valid <= w_xfer_a | w_xfer_b;
            if (w_xfer_a)
                r_out_data <= data_a;
            else if (w_xfer_b)
                r_out_data <= data_b;
        end
    end

`ifdef BYTE_ARB_STATS_EN
    logic        w_forced_switch;
    logic [15:0] r_xfer_cnt_a;
    logic [15:0] r_xfer_cnt_b;
    logic [7:0]  r_switch_cnt;

    // A forced switch is a last-of-burst transfer while the other side waits.
    assign w_forced_switch = (r_burst_cnt == c_LAST_CNT) &&
                             ((w_xfer_a && req_b) || (w_xfer_b && req_a));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_cnt_a <= 16'd0;
            r_xfer_cnt_b <= 16'd0;
            r_switch_cnt <= 8'd0;
        end else begin
            if (w_xfer_a)
                r_xfer_cnt_a <= r_xfer_cnt_a + 16'd1;
            if (w_xfer_b)
                r_xfer_cnt_b <= r_xfer_cnt_b + 16'd1;
            if (w_forced_switch)
                r_switch_cnt <= r_switch_cnt + 8'd1;
        end
    end

    assign xfer_cnt_a = r_xfer_cnt_a;
    assign xfer_cnt_b = r_xfer_cnt_b;
    assign switch_cnt = r_switch_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_byte_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_byte_bus_arbiter
//  Purpose  : Self-checking bench for byte_bus_arbiter: directed scenarios and
//             a randomized run against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_byte_bus_arbiter;

    localparam int MAX_BURST = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, req_b, out_ready;
    logic [7:0] data_a, data_b;
    logic       gnt_a, gnt_b, ack_a, ack_b, sel, out_valid;
    logic [7:0] out_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    byte_bus_arbiter #(.WIDTH(8), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .data_a    (data_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .out_ready (out_ready),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .ack_a     (ack_a),
        .ack_b     (ack_b),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b1;
        data_a = 8'h00; data_b = 8'h00;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b1;
        data_a = 8'hFF; data_b = 8'hFF;
        tick; tick;
        rst = 1'b0;
        repeat (5) tick;
        @(negedge clk);
        checks++;
        if ({gnt_a, gnt_b, sel, out_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got={gnt_a,gnt_b,sel,valid}=%b exp=0000", {gnt_a, gnt_b, sel, out_valid});
        end
        checks++;
        if (out_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data got=%h exp=00", out_data);
        end
        tick;
    endtask

    // Both requesting continuously: A x4, B x4, then A again, no idle gap.
    task automatic test_round_robin;
        logic [5:0] exp_v;
        logic [7:0] exp_d;
        bit         ea, eb;
        do_reset;
        req_a = 1'b1; req_b = 1'b1; data_a = 8'h44; data_b = 8'h25; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            ea    = (c >= 1 && c <= 4) || (c == 9);
            eb    = (c >= 5 && c <= 8);
            exp_v = {ea, eb, ea, eb, eb, (c >= 2)};
            exp_d = (c < 2) ? 8'h00 : ((c <= 5) ? 8'h44 : 8'h25);
            checks++;
            if ({gnt_a, gnt_b, ack_a, ack_b, sel, out_valid} !== exp_v) begin
                failures++;
                $display("FAIL rr_ctrl cyc=%0d got={ga,gb,aa,ab,sel,v}=%b exp=%b", c,
                         {gnt_a, gnt_b, ack_a, ack_b, sel, out_valid}, exp_v);
            end
            checks++;
            if (out_data !== exp_d) begin
                failures++;
                $display("FAIL rr_data cyc=%0d got=%h exp=%h", c, out_data, exp_d);
            end
            tick;
        end
    endtask

    // Lone requester keeps the bus across burst boundaries.
    task automatic test_single_b;
        int n_ack, n_val;
        n_ack = 0; n_val = 0;
        do_reset;
        req_b = 1'b1; data_b = 8'h83;
        for (int c = 0; c <= 10; c++) begin
            if (c == 10) req_b = 1'b0;
            @(negedge clk);
            if (c >= 1 && c <= 9) begin
                checks++;
                if (gnt_b !== 1'b1 || gnt_a !== 1'b0) begin
                    failures++;
                    $display("FAIL single_b_gnt cyc=%0d got={ga,gb}=%b%b exp=01", c, gnt_a, gnt_b);
                end
            end
            if (ack_b === 1'b1) n_ack++;
            if (out_valid === 1'b1 && out_data === 8'h83) n_val++;
            checks++;
            if (out_valid !== (c >= 2)) begin
                failures++;
                $display("FAIL single_b_valid cyc=%0d got=%b exp=%b", c, out_valid, (c >= 2));
            end
            tick;
        end
        checks++;
        if (n_ack != 9 || n_val != 9) begin
            failures++;
            $display("FAIL single_b_count got acks=%0d valids=%0d exp 9/9", n_ack, n_val);
        end
    endtask

    // Stall in GNT_A must not consume burst slots.
    task automatic test_stall;
        bit ga, gb, aa, ev;
        do_reset;
        req_a = 1'b1; data_a = 8'h99; data_b = 8'h11; out_ready = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            out_ready = (c >= 4);
            req_b     = (c >= 4);
            @(negedge clk);
            ga = (c >= 1 && c <= 7);
            aa = (c >= 4 && c <= 7);
            gb = (c == 8);
            ev = (c >= 5 && c <= 8);
            checks++;
            if ({gnt_a, gnt_b, ack_a, out_valid} !== {ga, gb, aa, ev}) begin
                failures++;
                $display("FAIL stall_ctrl cyc=%0d got={ga,gb,aa,v}=%b exp=%b", c,
                         {gnt_a, gnt_b, ack_a, out_valid}, {ga, gb, aa, ev});
            end
            if (c == 5) begin
                checks++;
                if (out_data !== 8'h99) begin
                    failures++;
                    $display("FAIL stall_data got=%h exp=99", out_data);
                end
            end
            tick;
        end
    endtask

    // Reset during A's burst clears everything and A again wins the tie.
    task automatic test_reset_mid_burst;
        do_reset;
        req_a = 1'b1; req_b = 1'b1; data_a = 8'h5A; data_b = 8'hC3; out_ready = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            rst = (c == 3);
            @(negedge clk);
            if (c == 4) begin
                checks++;
                if ({gnt_a, gnt_b, sel, out_valid} !== 4'b0000 || out_data !== 8'h00) begin
                    failures++;
                    $display("FAIL midrst_clear got={ga,gb,sel,v}=%b data=%h exp=0000/00",
                             {gnt_a, gnt_b, sel, out_valid}, out_data);
                end
            end
            if (c == 5) begin
                checks++;
                if ({gnt_a, gnt_b, ack_a} !== 3'b101) begin
                    failures++;
                    $display("FAIL midrst_regrant got={ga,gb,aa}=%b exp=101", {gnt_a, gnt_b, ack_a});
                end
            end
            tick;
        end
        rst = 1'b0;
    endtask

    // Randomized traffic against a transaction-level model: owner id,
    // transfers taken in the current tenure, and who held the bus last.
    task automatic test_random;
        int         m_owner, m_last, m_run, nxt, oth;
        bit         m_valid, m_sel, mine, other, ea, eb, prev_take_a, prev_take_b;
        logic [7:0] m_data;
        logic [5:0] exp_v;
        do_reset;
        m_owner = 0; m_last = 2; m_run = 0; m_valid = 0; m_sel = 0; m_data = 8'h00;
        prev_take_a = 1; prev_take_b = 1;
        for (int c = 0; c < 800; c++) begin
            rst       = ($urandom_range(0, 79) == 0);
            req_a     = ($urandom_range(0, 3) != 0);
            req_b     = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if (prev_take_a) data_a = 8'($urandom);
            if (prev_take_b) data_b = 8'($urandom);
            @(negedge clk);
            ea    = (m_owner == 1) && req_a && out_ready;
            eb    = (m_owner == 2) && req_b && out_ready;
            exp_v = {(m_owner == 1), (m_owner == 2), ea, eb, m_sel, m_valid};
            checks++;
            if ({gnt_a, gnt_b, ack_a, ack_b, sel, out_valid} !== exp_v) begin
                failures++;
                $display("FAIL rand_ctrl cyc=%0d got={ga,gb,aa,ab,sel,v}=%b exp=%b", c,
                         {gnt_a, gnt_b, ack_a, ack_b, sel, out_valid}, exp_v);
            end
            checks++;
            if (out_data !== m_data) begin
                failures++;
                $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, out_data, m_data);
            end
            prev_take_a = ea || !req_a;
            prev_take_b = eb || !req_b;
            if (rst) begin
                m_owner = 0; m_last = 2; m_run = 0; m_valid = 0; m_sel = 0; m_data = 8'h00;
            end else begin
                m_valid = ea || eb;
                if (ea) m_data = data_a;
                else if (eb) m_data = data_b;
                nxt = m_owner;
                if (m_owner == 0) begin
                    if (req_a && req_b) nxt = (m_last == 2) ? 1 : 2;
                    else if (req_a)     nxt = 1;
                    else if (req_b)     nxt = 2;
                end else begin
                    mine  = (m_owner == 1) ? req_a : req_b;
                    other = (m_owner == 1) ? req_b : req_a;
                    oth   = 3 - m_owner;
                    if (!mine) begin
                        nxt = other ? oth : 0;
                    end else if (out_ready) begin
                        m_run++;
                        if (m_run == MAX_BURST) begin
                            if (other) nxt = oth;
                            else       m_run = 0;
                        end
                    end
                end
                if (nxt != 0 && nxt != m_owner) begin
                    m_last = nxt;
                    m_run  = 0;
                end
                if (nxt != 0) m_sel = (nxt == 2);
                m_owner = nxt;
            end
            tick;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
        data_a = 8'h00; data_b = 8'h00;
        test_reset;
        test_round_robin;
        test_single_b;
        test_stall;
        test_reset_mid_burst;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
